// File: rtl/guess_checker.sv
// Mastermind-style scorer for the hex-digit guessing game: exact/misplaced
// hit counts, attempt counting and sticky win/lose flags.
module guess_checker #(
  parameter int MAX_TRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        check,
  input  logic        new_game,
  input  logic [15:0] guess,
  input  logic [15:0] secret,
  output logic [2:0]  exact,
  output logic [2:0]  partial,
  output logic [3:0]  attempts,
  output logic        busy,
  output logic        result_valid,
  output logic        win,
  output logic        lose
);

  typedef enum logic [1:0] {IDLE, EXACT, SCAN, DONE} state_t;

  state_t      state, state_next;
  logic        check_q;
  logic        start;
  logic        accept;
  logic [15:0] guess_w, secret_w;
  logic [3:0]  exact_mask;
  logic [3:0]  used;
  logic [2:0]  exact_cnt;
  logic [2:0]  partial_cnt;
  logic [1:0]  idx;
  logic [3:0]  digit_sel;
  logic [3:0]  claim_hot;
  logic [3:0]  attempts_inc;

  function automatic logic [2:0] count4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  function automatic logic [3:0] eq_mask(input logic [15:0] a, input logic [15:0] b);
    logic [3:0] m;
    for (int k = 0; k < 4; k++)
      m[k] = (a[4*k +: 4] == b[4*k +: 4]);
    return m;
  endfunction

  // One-hot of the highest free secret position holding this digit; ascending
  // loop so the last match (highest j) wins.
  function automatic logic [3:0] claim(input logic [3:0] digit, input logic [15:0] s,
                                       input logic [3:0] blocked);
    logic [3:0] c;
    c = 4'b0000;
    for (int j = 0; j < 4; j++)
      if (!blocked[j] && (s[4*j +: 4] == digit))
        c = 4'b0001 << j;
    return c;
  endfunction

  assign start        = check & ~check_q;
  assign digit_sel    = guess_w[{idx, 2'b00} +: 4];
  assign claim_hot    = exact_mask[idx] ? 4'b0000 : claim(digit_sel, secret_w, exact_mask | used);
  assign attempts_inc = (attempts == 4'hF) ? 4'hF : attempts + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      check_q <= 1'b0;
    end else begin
      state   <= state_next;
      check_q <= check;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start && !win && !lose) state_next = EXACT;
      EXACT: state_next = SCAN;
      SCAN:  if (idx == 2'd0) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (new_game)
      state_next = IDLE;
  end

  always_comb begin
    busy   = (state != IDLE);
    accept = (state == IDLE) && (state_next == EXACT);
  end

  // Operand capture and scoring datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      guess_w  <= guess;
      secret_w <= secret;
    end
    if (state == EXACT) begin
      exact_mask  <= eq_mask(guess_w, secret_w);
      exact_cnt   <= count4(eq_mask(guess_w, secret_w));
      used        <= 4'b0000;
      partial_cnt <= 3'd0;
    end else if (state == SCAN) begin
      used <= used | claim_hot;
      if (claim_hot != 4'b0000)
        partial_cnt <= partial_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      idx <= 2'd3;
    else if (state == EXACT)
      idx <= 2'd3;
    else if (state == SCAN)
      idx <= idx - 2'd1;
  end

  // Result, attempt and game-state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exact        <= 3'd0;
      partial      <= 3'd0;
      attempts     <= 4'd0;
      result_valid <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else if (new_game) begin
      exact        <= 3'd0;
      partial      <= 3'd0;
      attempts     <= 4'd0;
      result_valid <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      result_valid <= (state == DONE);
      if (state == DONE) begin
        exact    <= exact_cnt;
        partial  <= partial_cnt;
        attempts <= attempts_inc;
        if (exact_cnt == 3'd4)
          win <= 1'b1;
        else if (attempts_inc == 4'(MAX_TRIES))
          lose <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker with hand-computed scores and timing.
module tb_guess_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        check;
  logic        new_game;
  logic [15:0] guess;
  logic [15:0] secret;
  logic [2:0]  exact;
  logic [2:0]  partial;
  logic [3:0]  attempts;
  logic        busy;
  logic        result_valid;
  logic        win;
  logic        lose;

  int checks   = 0;
  int failures = 0;
  int pulses;

  guess_checker #(.MAX_TRIES(8)) dut (
    .clk(clk), .reset(reset), .check(check), .new_game(new_game),
    .guess(guess), .secret(secret), .exact(exact), .partial(partial),
    .attempts(attempts), .busy(busy), .result_valid(result_valid),
    .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One check edge, then wait (bounded) for the result pulse.
  task automatic run_check();
    int lat;
    @(negedge clk) check = 1'b1;
    @(negedge clk) check = 1'b0;
    lat = 1;
    chk("busy_start", 16'(busy), 16'd1);
    while (!result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 16'(lat), 16'd7);
    chk("busy_done", 16'(busy), 16'd0);
    @(negedge clk);
    chk("rv_single", 16'(result_valid), 16'd0);
  endtask

  task automatic do_new_game();
    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0;
  endtask

  task automatic count_pulses(input int n);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
  endtask

  initial begin
    reset = 1'b0; check = 1'b0; new_game = 1'b0;
    guess = 16'h0000; secret = 16'h0000;
    #12;
    chk("rst_exact", 16'(exact), 16'd0);
    chk("rst_partial", 16'(partial), 16'd0);
    chk("rst_attempts", 16'(attempts), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_rv", 16'(result_valid), 16'd0);
    chk("rst_win", 16'(win), 16'd0);
    chk("rst_lose", 16'(lose), 16'd0);
    @(negedge clk) reset = 1'b1;

    // Exact match wins; further checks ignored
    secret = 16'h1234; guess = 16'h1234;
    run_check();
    chk("win_exact", 16'(exact), 16'd4);
    chk("win_partial", 16'(partial), 16'd0);
    chk("win_attempts", 16'(attempts), 16'd1);
    chk("win_flag", 16'(win), 16'd1);
    @(negedge clk) check = 1'b1;
    @(negedge clk) check = 1'b0;
    chk("after_win_busy", 16'(busy), 16'd0);
    count_pulses(8);
    chk("after_win_pulses", 16'(pulses), 16'd0);
    chk("after_win_attempts", 16'(attempts), 16'd1);

    // Duplicates, all misplaced
    do_new_game();
    chk("ng_attempts", 16'(attempts), 16'd0);
    chk("ng_win", 16'(win), 16'd0);
    secret = 16'h1123; guess = 16'h3211;
    run_check();
    chk("dup_exact", 16'(exact), 16'd0);
    chk("dup_partial", 16'(partial), 16'd4);
    chk("dup_win", 16'(win), 16'd0);
    chk("dup_attempts", 16'(attempts), 16'd1);

    // Mixed exact and partial, then no hits
    do_new_game();
    secret = 16'hAAB0; guess = 16'hA0AA;
    run_check();
    chk("mix_exact", 16'(exact), 16'd1);
    chk("mix_partial", 16'(partial), 16'd2);
    guess = 16'h5678;
    run_check();
    chk("none_exact", 16'(exact), 16'd0);
    chk("none_partial", 16'(partial), 16'd0);
    chk("none_attempts", 16'(attempts), 16'd2);

    // Run out of tries
    do_new_game();
    secret = 16'h1234; guess = 16'h0000;
    for (int i = 1; i <= 8; i++) begin
      run_check();
      if (i == 7) chk("lose_early", 16'(lose), 16'd0);
    end
    chk("lose_flag", 16'(lose), 16'd1);
    chk("lose_win", 16'(win), 16'd0);
    chk("lose_attempts", 16'(attempts), 16'd8);
    @(negedge clk) check = 1'b1;
    @(negedge clk) check = 1'b0;
    chk("lose_ignored_busy", 16'(busy), 16'd0);
    count_pulses(10);
    chk("lose_ignored_pulses", 16'(pulses), 16'd0);
    chk("lose_ignored_attempts", 16'(attempts), 16'd8);

    // Held check gives one result; guess change after capture is ignored
    do_new_game();
    secret = 16'h1234; guess = 16'h1243;
    @(negedge clk) check = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) guess = 16'h1234;
      if (result_valid) pulses++;
    end
    check = 1'b0;
    chk("hold_pulses", 16'(pulses), 16'd1);
    chk("hold_exact", 16'(exact), 16'd2);
    chk("hold_partial", 16'(partial), 16'd2);
    chk("hold_attempts", 16'(attempts), 16'd1);

    // new_game aborts a run in progress
    guess = 16'h4321;
    @(negedge clk) check = 1'b1;
    @(negedge clk) check = 1'b0;
    @(negedge clk);
    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_attempts", 16'(attempts), 16'd0);
    count_pulses(10);
    chk("abort_pulses", 16'(pulses), 16'd0);
    chk("abort_exact", 16'(exact), 16'd0);

    // Asynchronous reset mid-run
    guess = 16'h1243;
    run_check();
    chk("pre_rst_exact", 16'(exact), 16'd2);
    @(negedge clk) check = 1'b1;
    @(negedge clk) check = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_exact", 16'(exact), 16'd0);
    chk("arst_partial", 16'(partial), 16'd0);
    chk("arst_attempts", 16'(attempts), 16'd0);
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_win_lose", {14'd0, win, lose}, 16'd0);
    @(negedge clk) reset = 1'b1;
    count_pulses(10);
    chk("arst_pulses", 16'(pulses), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
